// File: rtl/soc_io_pkg.sv
// Shared IO-page constants: UART RX word decode, status bit layout, RX FSM encoding.
package soc_io_pkg;

    localparam int IO_UART_RX_DAT_bit = 3;

    // Status bits sit above the data byte; bit 9 stays owned by the TX busy flag.
    localparam int RX_STAT_VALID_BIT   = 8;
    localparam int RX_STAT_BUSY_BIT    = 9;
    localparam int RX_STAT_OVERRUN_BIT = 10;
    localparam int RX_STAT_FRMERR_BIT  = 11;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    function automatic logic [31:0] rx_status_word(
        input logic [7:0] data,
        input logic       valid,
        input logic       busy,
        input logic       overrun,
        input logic       frame_err
    );
        logic [31:0] w;
        w                      = {24'd0, data};
        w[RX_STAT_VALID_BIT]   = valid;
        w[RX_STAT_BUSY_BIT]    = busy;
        w[RX_STAT_OVERRUN_BIT] = overrun;
        w[RX_STAT_FRMERR_BIT]  = frame_err;
        return w;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// First-word-fall-through byte FIFO; push while full is accepted only alongside a pop.
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     i_push,
    input  logic [7:0]               i_data,
    input  logic                     i_pop,
    output logic [7:0]               o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_pop;
    logic        w_push;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = i_pop && !o_empty;
    // When full, the slot being written is the head being popped this cycle.
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling feeding a byte FIFO drained by CPU IO reads.
module uart_rx_fifo
    import soc_io_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int BAUD_RATE   = 115200,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          i_rxd,
    input  logic                          i_rd,
    input  logic                          i_clr_err,
    output logic [7:0]                    o_data,
    output logic                          o_valid,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_overrun,
    output logic                          o_frame_err
);

    localparam int DIVISOR     = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CW          = $clog2(DIVISOR);
    localparam int SYNC_STAGES = 2;
    localparam logic [CW-1:0] CNT_RELOAD = CW'(DIVISOR - 1);
    localparam logic [CW-1:0] CNT_HALF   = CW'(DIVISOR / 2 - 1);

    logic                   r_rxd_meta;
    logic                   r_rx_s;
    logic                   r_rx_prev;
    logic [SYNC_STAGES:0]   r_vld_pipe;
    rx_state_e              r_state;
    logic [CW-1:0]          r_cnt;
    logic [2:0]             r_bit_idx;
    logic [7:0]             r_shift;
    logic                   r_overrun;
    logic                   r_frame_err;

    logic w_fall;
    logic w_tick;
    logic w_stop_tick;
    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_empty;
    logic w_ovr_set;
    logic w_ferr_set;

    // Edge detection is held off until every sync stage holds a real sample, so a
    // line already low at reset release is not mistaken for a start edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rxd_meta <= 1'b1;
            r_rx_s     <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_vld_pipe <= '0;
        end else begin
            r_rxd_meta <= i_rxd;
            r_rx_s     <= r_rxd_meta;
            r_rx_prev  <= r_rx_s;
            r_vld_pipe <= {r_vld_pipe[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign w_fall      = r_vld_pipe[SYNC_STAGES] && r_rx_prev && !r_rx_s;
    assign w_tick      = (r_cnt == '0);
    assign w_stop_tick = (r_state == RX_STOP) && w_tick;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= RX_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_cnt <= w_tick ? CNT_RELOAD : r_cnt - 1'b1;
            case (r_state)
                RX_IDLE: begin
                    if (w_fall) begin
                        r_cnt   <= CNT_HALF;
                        r_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (w_tick) begin
                        if (!r_rx_s) begin
                            r_bit_idx <= '0;
                            r_state   <= RX_DATA;
                        end else begin
                            r_state   <= RX_IDLE;
                        end
                    end
                end
                RX_DATA: begin
                    if (w_tick) begin
                        r_shift   <= {r_rx_s, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7) r_state <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    // Leave at mid-stop-bit so a back-to-back start edge is caught.
                    if (w_tick) r_state <= RX_IDLE;
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    assign w_push     = w_stop_tick && r_rx_s;
    assign w_pop      = i_rd && o_valid;
    assign w_ovr_set  = w_push && w_full && !w_pop;
    assign w_ferr_set = w_stop_tick && !r_rx_s;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_overrun   <= w_ovr_set  | (r_overrun   & ~i_clr_err);
            r_frame_err <= w_ferr_set | (r_frame_err & ~i_clr_err);
        end
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_push),
        .i_data  (r_shift),
        .i_pop   (i_rd),
        .o_data  (o_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (o_count)
    );

    assign o_valid     = !w_empty;
    assign o_overrun   = r_overrun;
    assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboarded bench for uart_rx_fifo: directed frames in, expected bytes queued, monitor checks pops.
module tb_uart_rx_fifo;

    localparam int DIV = 16;

    logic       clk = 1'b0;
    logic       resetn;
    logic       i_rxd;
    logic       i_rd;
    logic       i_clr_err;
    logic [7:0] o_data;
    logic       o_valid;
    logic [2:0] o_count;
    logic       o_overrun;
    logic       o_frame_err;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         t0;
    int         lat;
    logic [7:0] expq [$];
    logic [7:0] mon_exp;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_fifo #(
        .CLK_FREQ_HZ (16),
        .BAUD_RATE   (1),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .i_rxd       (i_rxd),
        .i_rd        (i_rd),
        .i_clr_err   (i_clr_err),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_count     (o_count),
        .o_overrun   (o_overrun),
        .o_frame_err (o_frame_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        i_rxd = 1'b0;
        cyc_wait(DIV);
        for (int i = 0; i < 8; i++) begin
            i_rxd = b[i];
            cyc_wait(DIV);
        end
        i_rxd = stop;
        cyc_wait(DIV);
        i_rxd = 1'b1;
    endtask

    task automatic read_one();
        i_rd = 1'b1;
        cyc_wait(1);
        i_rd = 1'b0;
    endtask

    task automatic pulse_clr();
        i_clr_err = 1'b1;
        cyc_wait(1);
        i_clr_err = 1'b0;
    endtask

    // Monitor: every accepted pop must match the oldest expected byte.
    always @(negedge clk) begin
        if (resetn && i_rd && o_valid) begin
            if (expq.size() == 0) begin
                check("sb_unexpected_pop", {24'd0, o_data}, 32'hFFFF_FFFF);
            end else begin
                mon_exp = expq.pop_front();
                check("sb_rx_data", {24'd0, o_data}, {24'd0, mon_exp});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        resetn = 1'b0; i_rxd = 1'b1; i_rd = 1'b0; i_clr_err = 1'b0;
        cyc_wait(3);
        check("rst_valid",     o_valid,     0);
        check("rst_count",     o_count,     0);
        check("rst_overrun",   o_overrun,   0);
        check("rst_frame_err", o_frame_err, 0);
        resetn = 1'b1;
        cyc_wait(5);

        // 1: single frame, latency and pop
        expq.push_back(8'hA5);
        t0  = cyc;
        lat = -1;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                for (int k = 0; k < 200 && lat < 0; k++) begin
                    @(negedge clk);
                    if (o_valid) lat = cyc - t0;
                end
            end
        join
        check("t1_latency_window", (lat >= 154 && lat <= 156), 1);
        check("t1_count", o_count, 1);
        check("t1_head",  o_data,  8'hA5);
        read_one();
        check("t1_valid_after_pop", o_valid, 0);
        check("t1_count_after_pop", o_count, 0);

        // 2: short low pulse is rejected
        i_rxd = 1'b0;
        cyc_wait(4);
        i_rxd = 1'b1;
        cyc_wait(40);
        check("t2_count",     o_count,     0);
        check("t2_valid",     o_valid,     0);
        check("t2_overrun",   o_overrun,   0);
        check("t2_frame_err", o_frame_err, 0);

        // 3: overrun on the fifth byte
        for (int b = 1; b <= 4; b++) expq.push_back(8'(b));
        for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1);
        cyc_wait(4);
        check("t3_count",   o_count,   4);
        check("t3_overrun", o_overrun, 1);
        check("t3_head",    o_data,    8'h01);
        repeat (4) read_one();
        check("t3_count_drained",  o_count,   0);
        check("t3_overrun_sticky", o_overrun, 1);
        pulse_clr();
        check("t3_overrun_cleared", o_overrun, 0);

        // read while empty is ignored
        read_one();
        check("empty_rd_count", o_count, 0);
        check("empty_rd_valid", o_valid, 0);

        // 4: framing error, clear in the same cycle as the set loses
        fork
            send_frame(8'h3C, 1'b0);
            begin
                cyc_wait(154);
                i_clr_err = 1'b1;
                cyc_wait(1);
                i_clr_err = 1'b0;
            end
        join
        cyc_wait(DIV);
        check("t4_frame_err", o_frame_err, 1);
        check("t4_count",     o_count,     0);
        check("t4_overrun",   o_overrun,   0);
        expq.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        cyc_wait(2);
        check("t4_next_count", o_count, 1);
        check("t4_next_head",  o_data,  8'h7E);
        read_one();
        check("t4_frame_err_sticky", o_frame_err, 1);
        pulse_clr();
        check("t4_frame_err_cleared", o_frame_err, 0);

        // 5: pop in the stop-sample cycle while full
        for (int b = 8'h10; b <= 8'h13; b++) begin
            expq.push_back(8'(b));
            send_frame(8'(b), 1'b1);
        end
        cyc_wait(2);
        check("t5_full_count", o_count, 4);
        expq.push_back(8'h14);
        fork
            send_frame(8'h14, 1'b1);
            begin
                cyc_wait(154);
                i_rd = 1'b1;
                cyc_wait(1);
                i_rd = 1'b0;
            end
        join
        cyc_wait(2);
        check("t5_count",   o_count,   4);
        check("t5_overrun", o_overrun, 0);
        check("t5_head",    o_data,    8'h11);
        repeat (4) read_one();
        check("t5_drained", o_count, 0);

        // 6: reset mid-frame with a byte buffered and an error flag set
        send_frame(8'hFF, 1'b0);
        cyc_wait(DIV);
        expq.push_back(8'h42);
        send_frame(8'h42, 1'b1);
        cyc_wait(2);
        check("t6_pre_count",     o_count,     1);
        check("t6_pre_frame_err", o_frame_err, 1);
        i_rxd = 1'b0;
        cyc_wait(DIV * 4 + DIV / 2);
        resetn = 1'b0;
        expq.delete();
        cyc_wait(2);
        check("t6_rst_count",     o_count,     0);
        check("t6_rst_valid",     o_valid,     0);
        check("t6_rst_overrun",   o_overrun,   0);
        check("t6_rst_frame_err", o_frame_err, 0);
        resetn = 1'b1;
        cyc_wait(200);
        check("t6_low_count",     o_count,     0);
        check("t6_low_valid",     o_valid,     0);
        check("t6_low_frame_err", o_frame_err, 0);
        i_rxd = 1'b1;
        cyc_wait(DIV);
        expq.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        cyc_wait(2);
        check("t6_new_count", o_count, 1);
        check("t6_new_head",  o_data,  8'h5A);
        read_one();
        check("t6_new_drained", o_count, 0);

        cyc_wait(2);
        check("sb_all_consumed", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
